washer_plant_model: RTL and testbench

- Responder-side plant model for the washing-machine controller.
- Consumes the controller's actuator outputs: valves, motor, lock and phase flags.
- Produces the sensor and timer inputs the controller waits on: filled, drained, detergent_added, cycle_timeout, spin_timeout.
- Closes the loop for system simulation; also usable as on-chip phase-timer logic next to the controller.

---
 rtl/washer_pkg.sv | 32 +++
 rtl/washer_phase_timer.sv | 28 ++
 rtl/washer_plant_model.sv | 144 ++++++++++++++
 tb/tb_washer_plant_model.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared constants, fault codes and phase-flag encoding for the washer controller and plant model.
package washer_pkg;

  localparam int DEF_LEVEL_W     = 8;
  localparam int DEF_FULL_LEVEL  = 200;
  localparam int DEF_FILL_RATE   = 1;
  localparam int DEF_DRAIN_RATE  = 2;
  localparam int DEF_TMR_W       = 16;
  localparam int DEF_WASH_CYCLES = 1000;
  localparam int DEF_SPIN_CYCLES = 500;
  localparam int DEF_DET_CYCLES  = 16;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_DOOR     = 2'b01,
    FLT_DRY      = 2'b10,
    FLT_OVERFILL = 2'b11
  } fault_t;

  // Phase encoding as {water_wash, soap_wash}; both set is not a legal controller phase.
  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_SOAP  = 2'b01,
    PH_RINSE = 2'b10,
    PH_BOTH  = 2'b11
  } phase_t;

  function automatic phase_t phase_of(input logic soap_wash, input logic water_wash);
    return phase_t'({water_wash, soap_wash});
  endfunction

endpackage

// File: rtl/washer_phase_timer.sv
// Saturating phase timer: counts while enabled, clears whenever enable drops, flags terminal count.
module washer_phase_timer #(
  parameter int TMR_W    = 16,
  parameter int TERMINAL = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic done
);

  localparam logic [TMR_W-1:0] TERM = TERMINAL[TMR_W-1:0];

  logic [TMR_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (!enable) begin
      count_reg <= '0;
    end else if (count_reg != TERM) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == TERM);

endmodule

// File: rtl/washer_plant_model.sv
// Plant model closing the loop around the washer controller: water level, phase timers, dispenser.
// Optional fault detector (fault, fault_code ports) is compiled in with WASHER_FAULT_DET_EN.
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int FULL_LEVEL  = DEF_FULL_LEVEL,
  parameter int FILL_RATE   = DEF_FILL_RATE,
  parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
  parameter int TMR_W       = DEF_TMR_W,
  parameter int WASH_CYCLES = DEF_WASH_CYCLES,
  parameter int SPIN_CYCLES = DEF_SPIN_CYCLES,
  parameter int DET_CYCLES  = DEF_DET_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               motor_on,
  input  logic               fill_valve_on,
  input  logic               drain_valve_on,
  input  logic               door_lock,
  input  logic               soap_wash,
  input  logic               water_wash,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] water_level
`ifdef WASHER_FAULT_DET_EN
  ,
  output logic               fault,
  output logic [1:0]         fault_code
`endif
);

  if (FULL_LEVEL >= 2**LEVEL_W) begin : g_chk_level
    $error("FULL_LEVEL does not fit in LEVEL_W bits");
  end
  if (WASH_CYCLES >= 2**TMR_W || SPIN_CYCLES >= 2**TMR_W || DET_CYCLES >= 2**TMR_W) begin : g_chk_tmr
    $error("phase cycle count does not fit in TMR_W bits");
  end

  localparam logic signed [LEVEL_W+1:0] FR = FILL_RATE[LEVEL_W+1:0];
  localparam logic signed [LEVEL_W+1:0] DR = DRAIN_RATE[LEVEL_W+1:0];
  localparam logic signed [LEVEL_W+1:0] FL = FULL_LEVEL[LEVEL_W+1:0];

  logic [LEVEL_W-1:0]        level_reg;
  logic [LEVEL_W-1:0]        level_next;
  logic signed [LEVEL_W+1:0] level_sum;
  logic                      det_flag_reg;
  logic [2:0]                tmr_en;
  logic [2:0]                tmr_done;
  logic                      det_en;

  // Two extra bits give headroom for both overflow above FULL_LEVEL and underflow below 0.
  always_comb begin
    level_sum = $signed({2'b00, level_reg});
    if (fill_valve_on) level_sum = level_sum + FR;
    if (drain_valve_on) level_sum = level_sum - DR;
    if (level_sum < 0) begin
      level_next = '0;
    end else if (level_sum > FL) begin
      level_next = FL[LEVEL_W-1:0];
    end else begin
      level_next = level_sum[LEVEL_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign filled      = (level_reg == FL[LEVEL_W-1:0]);
  assign drained     = (level_reg == '0);
  assign water_level = level_reg;

  assign det_en = (phase_of(soap_wash, water_wash) == PH_SOAP) & filled &
                  ~motor_on & ~fill_valve_on & ~drain_valve_on;
  assign tmr_en = {det_en, drain_valve_on & water_wash & drained, motor_on};

  // Index 0 = wash, 1 = spin, 2 = detergent dispenser.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tmr
    localparam int TERM = (gi == 0) ? WASH_CYCLES : (gi == 1) ? SPIN_CYCLES : DET_CYCLES;
    washer_phase_timer #(
      .TMR_W   (TMR_W),
      .TERMINAL(TERM)
    ) u_tmr (
      .clock (clock),
      .reset (reset),
      .enable(tmr_en[gi]),
      .done  (tmr_done[gi])
    );
  end

  assign cycle_timeout = tmr_done[0];
  assign spin_timeout  = tmr_done[1];

  // Terminal count is visible immediately; the flag keeps it after the dispense phase ends.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_flag_reg <= 1'b0;
    end else if (drained && drain_valve_on) begin
      det_flag_reg <= 1'b0;
    end else if (tmr_done[2]) begin
      det_flag_reg <= 1'b1;
    end
  end

  assign detergent_added = det_flag_reg | tmr_done[2];

`ifdef WASHER_FAULT_DET_EN
  logic   fault_reg;
  fault_t fault_code_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_reg      <= 1'b0;
      fault_code_reg <= FLT_NONE;
    end else if (!fault_reg) begin
      if (fill_valve_on && !door_lock) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= FLT_DOOR;
      end else if (motor_on && drained) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= FLT_DRY;
      end else if (fill_valve_on && filled) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= FLT_OVERFILL;
      end
    end
  end

  assign fault      = fault_reg;
  assign fault_code = fault_code_reg;
`else
  logic unused_door_lock;
  assign unused_door_lock = door_lock;
`endif

endmodule

// File: tb/tb_washer_plant_model.sv
// Scoreboard bench for washer_plant_model: directed plant scenarios plus randomized actuator bursts.
module tb_washer_plant_model;

  localparam int LEVEL_W = 8;
  localparam int FULL    = 10;
  localparam int FR      = 1;
  localparam int DR      = 2;
  localparam int WASH    = 5;
  localparam int SPIN    = 4;
  localparam int DET     = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic motor_on = 0, fill_valve_on = 0, drain_valve_on = 0;
  logic door_lock = 1, soap_wash = 0, water_wash = 0;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout;
  logic [LEVEL_W-1:0] water_level;
`ifdef WASHER_FAULT_DET_EN
  logic       fault;
  logic [1:0] fault_code;
`endif

  washer_plant_model #(
    .LEVEL_W(LEVEL_W), .FULL_LEVEL(FULL), .FILL_RATE(FR), .DRAIN_RATE(DR),
    .TMR_W(16), .WASH_CYCLES(WASH), .SPIN_CYCLES(SPIN), .DET_CYCLES(DET)
  ) dut (
    .clock(clock), .reset(reset), .motor_on(motor_on), .fill_valve_on(fill_valve_on),
    .drain_valve_on(drain_valve_on), .door_lock(door_lock), .soap_wash(soap_wash),
    .water_wash(water_wash), .filled(filled), .drained(drained),
    .detergent_added(detergent_added), .cycle_timeout(cycle_timeout),
    .spin_timeout(spin_timeout), .water_level(water_level)
`ifdef WASHER_FAULT_DET_EN
    , .fault(fault), .fault_code(fault_code)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int level;
    bit filled, drained, dadd, cto, sto, flt;
    int fcode;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Reference state: physical water level, elapsed phase times and sticky flags.
  int  m_level, m_wash_t, m_spin_t, m_det_t, m_fcode;
  bit  m_dadd, m_flt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int lim);
    return (v + 1 > lim) ? lim : v + 1;
  endfunction

  task automatic model_reset();
    m_level = 0; m_wash_t = 0; m_spin_t = 0; m_det_t = 0;
    m_dadd = 0; m_flt = 0; m_fcode = 0;
  endtask

  task automatic step(input bit f, input bit d, input bit m, input bit s, input bit w, input bit l);
    bit   full_now, empty_now;
    int   nl;
    exp_t e;
    fill_valve_on = f; drain_valve_on = d; motor_on = m;
    soap_wash = s; water_wash = w; door_lock = l;
    full_now  = (m_level == FULL);
    empty_now = (m_level == 0);
    if (!m_flt) begin
      if (f && !l)              begin m_flt = 1; m_fcode = 1; end
      else if (m && empty_now)  begin m_flt = 1; m_fcode = 2; end
      else if (f && full_now)   begin m_flt = 1; m_fcode = 3; end
    end
    nl = m_level + (f ? FR : 0) - (d ? DR : 0);
    if (nl < 0) nl = 0;
    if (nl > FULL) nl = FULL;
    m_level  = nl;
    m_wash_t = m ? sat_inc(m_wash_t, WASH) : 0;
    m_spin_t = (d && w && empty_now) ? sat_inc(m_spin_t, SPIN) : 0;
    m_det_t  = (s && !w && full_now && !m && !f && !d) ? sat_inc(m_det_t, DET) : 0;
    if (empty_now && d) m_dadd = 0;
    if (m_det_t == DET) m_dadd = 1;
    e.level = m_level; e.filled = (m_level == FULL); e.drained = (m_level == 0);
    e.dadd = m_dadd; e.cto = (m_wash_t == WASH); e.sto = (m_spin_t == SPIN);
    e.flt = m_flt; e.fcode = m_fcode;
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, water_level, 0);
    check({tag, "_filled"}, filled, 0);
    check({tag, "_drained"}, drained, 1);
    check({tag, "_det"}, detergent_added, 0);
    check({tag, "_cto"}, cycle_timeout, 0);
    check({tag, "_sto"}, spin_timeout, 0);
`ifdef WASHER_FAULT_DET_EN
    check({tag, "_fault"}, fault, 0);
    check({tag, "_fcode"}, fault_code, 0);
`endif
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      $display("txn %0d level=%0d filled=%0d drained=%0d det=%0d cto=%0d sto=%0d",
               txn, water_level, filled, drained, detergent_added, cycle_timeout, spin_timeout);
      check("level", water_level, e.level);
      check("filled", filled, e.filled);
      check("drained", drained, e.drained);
      check("detergent_added", detergent_added, e.dadd);
      check("cycle_timeout", cycle_timeout, e.cto);
      check("spin_timeout", spin_timeout, e.sto);
`ifdef WASHER_FAULT_DET_EN
      check("fault", fault, e.flt);
      check("fault_code", fault_code, e.fcode);
`endif
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int mode, len;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;

    // Fill to full and keep filling.
    repeat (12) step(1, 0, 0, 0, 0, 1);
    // Drain to empty and beyond, then refill to 5 and apply fill+drain.
    repeat (7) step(0, 1, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    // Wash timer: timeout, drop, interrupted pulses, then saturation hold.
    repeat (5) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0, 1);
    repeat (7) step(0, 0, 1, 0, 0, 1);
    // Detergent: refill, dispense, wash with motor, drain to clear.
    repeat (6) step(1, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 1, 0, 1);
    repeat (5) step(0, 0, 1, 1, 0, 1);
    repeat (7) step(0, 1, 0, 1, 0, 1);
    // Spin on an empty tub, then asynchronous reset mid-spin.
    repeat (6) step(0, 1, 0, 0, 1, 1);
    repeat (2) step(0, 1, 0, 0, 1, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
`ifdef WASHER_FAULT_DET_EN
    // Fill with door open, then lock: fault code must persist.
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("fault_reset");
    model_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
`endif
    // Randomized bursts of controller-like phases and unconstrained actuators.
    for (int b = 0; b < 40; b++) begin
      mode = $urandom_range(0, 4);
      len  = $urandom_range(3, 16);
      for (int k = 0; k < len; k++) begin
        case (mode)
          0: step(1, 0, 0, 0, 0, 1);
          1: step(0, 1, 0, 0, 1, 1);
          2: step(0, 0, 0, 1, 0, 1);
          3: step(0, 0, 1, $urandom_range(0, 1), 0, 1);
          default: step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
        endcase
      end
    end
    @(posedge clock); #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
